mmix_opfetch: RTL

Operand-fetch stage of the MMIX pipeline. It sits between decode and execute and is the requesting side of the `regs` read-port protocol (`raN_req`/`raN` out, `rdN_valid`/`rdN` in). It accepts one decoded instruction at a time and issues register reads for the $X, $Y and $Z fields that need them. It collects the returned words, substitutes zero-extended immediates where flagged, and presents all three operands to execute under a valid/ready handshake.

---
 rtl/mmix_pkg.sv | 24 ++
 rtl/rd_port_client.sv | 71 +++++++
 rtl/mmix_opfetch.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mmix_pkg.sv
// mmix_pkg: types shared by the MMIX operand-fetch stage.
//   reg_addr_t  - register address (8 bits, $0..$255)
//   word_t      - 64-bit data word
//   opf_state_t - operand-fetch FSM states
//   PORT_*      - index of each read-port client inside the stage
package mmix_pkg;

    typedef logic [7:0]  reg_addr_t;
    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } opf_state_t;

    // Port 1 reads Y, port 2 reads Z, port 3 reads X.
    localparam int NPORTS = 3;
    localparam int PORT_Y = 0;
    localparam int PORT_Z = 1;
    localparam int PORT_X = 2;

endpackage

// File: rtl/rd_port_client.sv
// rd_port_client: requesting side of one regs read port.
// Owns the registered request flop, the address latch and the data capture
// register for a single port.
//   clk, reset_n  - clock, asynchronous active-low reset
//   start         - load a new instruction (clears data, latches addr)
//   need          - this port must issue a read for the new instruction
//   keep          - store returned data (low while draining a flushed read)
//   addr          - register address to read
//   rd_valid, rd  - one-cycle read response from regs
//   req, req_addr - request and address driven to regs
//   pending       - a read is outstanding on this port
//   data          - captured word (0 when the port was not used)
module rd_port_client #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          need,
    input  logic          keep,
    input  logic [AW-1:0] addr,
    input  logic          rd_valid,
    input  logic [DW-1:0] rd,
    output logic          req,
    output logic [AW-1:0] req_addr,
    output logic          pending,
    output logic [DW-1:0] data
);

    logic          req_q,  req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    // The request stays up exactly as long as the read is outstanding, so the
    // request flop doubles as the pending bit.
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        data_d = data_q;
        if (start) begin
            req_d  = need;
            addr_d = addr;
            data_d = '0;
        end else if (req_q && rd_valid) begin
            // Responses on an idle port are ignored by the req_q guard.
            req_d = 1'b0;
            if (keep) begin
                data_d = rd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign req      = req_q;
    assign req_addr = addr_q;
    assign pending  = req_q;
    assign data     = data_q;

endmodule

// File: rtl/mmix_opfetch.sv
// mmix_opfetch: MMIX operand-fetch stage between decode and execute.
// Accepts one decoded instruction, reads $Y/$Z/$X through three regs read
// ports, substitutes zero-extended immediates and hands the operands to
// execute under a valid/ready handshake.
//   clk, reset_n              - clock, asynchronous active-low reset
//   in_valid/in_ready         - decode handshake
//   in_x/in_y/in_z            - instruction fields
//   in_x_rd/in_y_imm/in_z_imm - read $X / Y immediate / Z immediate
//   flush                     - abandon the current instruction
//   raN_req/raN               - read requests (1=Y, 2=Z, 3=X)
//   rdN_valid/rdN             - read responses
//   op_valid/op_ready         - execute handshake
//   op_x/op_y/op_z            - operands
module mmix_opfetch
    import mmix_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_x,
    input  logic [AW-1:0] in_y,
    input  logic [AW-1:0] in_z,
    input  logic          in_x_rd,
    input  logic          in_y_imm,
    input  logic          in_z_imm,
    input  logic          flush,
    output logic          ra1_req,
    output logic          ra2_req,
    output logic          ra3_req,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    output logic [AW-1:0] ra3,
    input  logic          rd1_valid,
    input  logic          rd2_valid,
    input  logic          rd3_valid,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    input  logic [DW-1:0] rd3,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_x,
    output logic [DW-1:0] op_y,
    output logic [DW-1:0] op_z
);

    opf_state_t    state_q, state_d;
    logic [AW-1:0] y_q, z_q;
    logic          y_imm_q, z_imm_q;

    logic              accept;
    logic              keep;
    logic              still_pending;
    logic [NPORTS-1:0] need;
    logic [NPORTS-1:0] rd_valid_v;
    logic [NPORTS-1:0] req_v;
    logic [NPORTS-1:0] pend_v;
    logic [AW-1:0]     fld_v  [NPORTS];
    logic [AW-1:0]     addr_v [NPORTS];
    logic [DW-1:0]     rd_v   [NPORTS];
    logic [DW-1:0]     data_v [NPORTS];

    // Gating with reset_n keeps in_ready low while reset is held even though
    // the state register already reads IDLE.
    assign in_ready = reset_n && (state_q == IDLE);
    assign accept   = in_ready && in_valid;
    assign keep     = (state_q != DRAIN);

    assign need[PORT_Y] = !in_y_imm;
    assign need[PORT_Z] = !in_z_imm;
    assign need[PORT_X] = in_x_rd;

    assign fld_v[PORT_Y] = in_y;
    assign fld_v[PORT_Z] = in_z;
    assign fld_v[PORT_X] = in_x;

    assign rd_valid_v[PORT_Y] = rd1_valid;
    assign rd_valid_v[PORT_Z] = rd2_valid;
    assign rd_valid_v[PORT_X] = rd3_valid;

    assign rd_v[PORT_Y] = rd1;
    assign rd_v[PORT_Z] = rd2;
    assign rd_v[PORT_X] = rd3;

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            rd_port_client #(
                .AW(AW),
                .DW(DW)
            ) u_client (
                .clk      (clk),
                .reset_n  (reset_n),
                .start    (accept),
                .need     (need[gi]),
                .keep     (keep),
                .addr     (fld_v[gi]),
                .rd_valid (rd_valid_v[gi]),
                .rd       (rd_v[gi]),
                .req      (req_v[gi]),
                .req_addr (addr_v[gi]),
                .pending  (pend_v[gi]),
                .data     (data_v[gi])
            );
        end
    endgenerate

    // Reads still outstanding after this edge's responses are taken.
    assign still_pending = |(pend_v & ~rd_valid_v);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (|need) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (flush) begin
                    state_d = still_pending ? DRAIN : IDLE;
                end else if (!still_pending) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (!still_pending) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                // flush wins over op_ready: either way we return to IDLE, but
                // execute must treat a flushed cycle as no transfer.
                if (flush || op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            z_q     <= '0;
            y_imm_q <= 1'b0;
            z_imm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                y_q     <= in_y;
                z_q     <= in_z;
                y_imm_q <= in_y_imm;
                z_imm_q <= in_z_imm;
            end
        end
    end

    assign ra1_req = req_v[PORT_Y];
    assign ra2_req = req_v[PORT_Z];
    assign ra3_req = req_v[PORT_X];
    assign ra1     = addr_v[PORT_Y];
    assign ra2     = addr_v[PORT_Z];
    assign ra3     = addr_v[PORT_X];

    assign op_valid = (state_q == DONE);
    assign op_y     = y_imm_q ? {{(DW-AW){1'b0}}, y_q} : data_v[PORT_Y];
    assign op_z     = z_imm_q ? {{(DW-AW){1'b0}}, z_q} : data_v[PORT_Z];
    assign op_x     = data_v[PORT_X];

endmodule
